// File: rtl/seq_pkg.sv
// Shared types and constants for the execution sequencer.
package seq_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'b00,
      SEQ_RUN    = 2'b01,
      SEQ_HALTED = 2'b10
   } seq_state_e;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/btn_sync_edge.sv
// Push-button synchroniser with rising-edge pulse output.
// Define SEQ_DEBOUNCE_EN to insert a stable-time debounce filter before edge detection.
module btn_sync_edge #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic edge_o
);

   logic s1_q, s2_q;
   logic level;
   logic levelDly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_i;
         s2_q <= s1_q;
      end
   end

`ifdef SEQ_DEBOUNCE_EN
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             deb_q, deb_d;
   logic [DEB_W-1:0] debCnt_q, debCnt_d;

   // The filtered level only follows s2 after it has disagreed for a full stable window.
   always_comb begin
      deb_d    = deb_q;
      debCnt_d = '0;
      if (s2_q != deb_q) begin
         if (debCnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = s2_q;
         end else begin
            debCnt_d = debCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_q    <= 1'b0;
         debCnt_q <= '0;
      end else begin
         deb_q    <= deb_d;
         debCnt_q <= debCnt_d;
      end
   end

   assign level = deb_q;
`else
   assign level = s2_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         levelDly_q <= 1'b0;
      end else begin
         levelDly_q <= level;
      end
   end

   assign edge_o = level & ~levelDly_q;

endmodule

// File: rtl/exec_sequencer.sv
// PC sequencer: free-run at a divided rate, single-step from a button, or halt on request.
// Optional step-button debounce is enabled by defining SEQ_DEBOUNCE_EN.
module exec_sequencer
   import seq_pkg::*;
#(
   parameter int                  PC_WIDTH        = 32,
   parameter logic [PC_WIDTH-1:0] PC_RESET        = '0,
   parameter int                  TICK_DIV        = 50_000_000,
   parameter int                  DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_sw,
   input  logic                step_btn,
   input  logic                halt_req,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_next,
   output logic                commit,
   output logic [1:0]          state
);

   localparam int TICK_W = $clog2(TICK_DIV);

   seq_state_e          state_q, state_d;
   logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
   logic [PC_WIDTH-1:0] pc_q;
   logic                commit_q;
   logic                doCommit;
   logic                stepEdge;
   logic                tick;

   btn_sync_edge #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step (
      .clk   (clk),
      .rst   (rst),
      .btn_i (step_btn),
      .edge_o(stepEdge)
   );

   assign pc_next = branch_taken ? {branch_target[PC_WIDTH-1:2], 2'b00}
                                 : pc_q + PC_WIDTH'(PC_STEP);

   assign tick = (tickCnt_q == TICK_W'(TICK_DIV - 1));

   // A halt request only has effect in a cycle that would otherwise commit.
   always_comb begin
      state_d   = state_q;
      tickCnt_d = tickCnt_q;
      doCommit  = 1'b0;
      unique case (state_q)
         SEQ_IDLE: begin
            tickCnt_d = '0;
            if (run_sw) begin
               state_d = SEQ_RUN;
            end else if (stepEdge) begin
               if (halt_req) state_d  = SEQ_HALTED;
               else          doCommit = 1'b1;
            end
         end
         SEQ_RUN: begin
            if (!run_sw) begin
               state_d   = SEQ_IDLE;
               tickCnt_d = '0;
            end else if (tick) begin
               tickCnt_d = '0;
               if (halt_req) state_d  = SEQ_HALTED;
               else          doCommit = 1'b1;
            end else begin
               tickCnt_d = tickCnt_q + 1'b1;
            end
         end
         SEQ_HALTED: begin
            tickCnt_d = '0;
            if (!run_sw && stepEdge) state_d = SEQ_IDLE;
         end
         default: begin
            state_d   = SEQ_IDLE;
            tickCnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SEQ_IDLE;
         tickCnt_q <= '0;
         pc_q      <= PC_RESET;
         commit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tickCnt_q <= tickCnt_d;
         commit_q  <= doCommit;
         if (doCommit) pc_q <= pc_next;
      end
   end

   assign pc     = pc_q;
   assign commit = commit_q;
   assign state  = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (TICK_DIV=4, DEBOUNCE_CYCLES=3, PC_RESET=0).
// Step timing expectations follow SEQ_DEBOUNCE_EN when it is defined.
module tb_exec_sequencer;

   localparam int PC_WIDTH = 32;
`ifdef SEQ_DEBOUNCE_EN
   localparam int STEP_LAT = 5;
   localparam int PRESS    = 4;
`else
   localparam int STEP_LAT = 2;
   localparam int PRESS    = 1;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic                run_sw;
   logic                step_btn;
   logic                halt_req;
   logic                branch_taken;
   logic [PC_WIDTH-1:0] branch_target;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_next;
   logic                commit;
   logic [1:0]          state;

   int nChecks = 0;
   int nFails  = 0;

   exec_sequencer #(
      .PC_WIDTH       (PC_WIDTH),
      .PC_RESET       (32'h0),
      .TICK_DIV       (4),
      .DEBOUNCE_CYCLES(3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run_sw       (run_sw),
      .step_btn     (step_btn),
      .halt_req     (halt_req),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (pc),
      .pc_next      (pc_next),
      .commit       (commit),
      .state        (state)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus();
      rst = 1'b1;
      run_sw = 1'b0;
      step_btn = 1'b0;
      halt_req = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      cyc(2);
      rst = 1'b0;
   endtask

   // Returns right after the edge at which the step commit (or transition) lands.
   task automatic applyStep();
      step_btn = 1'b1;
      cyc(PRESS);
      step_btn = 1'b0;
      cyc(STEP_LAT - PRESS + 1);
   endtask

   task automatic settleButton();
      step_btn = 1'b0;
      cyc(8);
   endtask

   task automatic test_reset();
      applyStimulus();
      nChecks++; if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL reset_commit: got %b expected 0", commit); end
      nChecks++; if (state !== 2'b00) begin nFails++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
      nChecks++; if (pc_next !== 32'h4) begin nFails++; $display("[TB] FAIL reset_pc_next: got %h expected %h", pc_next, 32'h4); end
   endtask

   task automatic test_run();
      logic expCommit;
      logic [31:0] expPc;
      applyStimulus();
      run_sw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         expCommit = (i > 1) && ((i - 1) % 4 == 0);
         expPc = 32'(4 * ((i - 1) / 4));
         nChecks++; if (commit !== expCommit) begin nFails++; $display("[TB] FAIL run_commit[%0d]: got %b expected %b", i, commit, expCommit); end
         nChecks++; if (pc !== expPc) begin nFails++; $display("[TB] FAIL run_pc[%0d]: got %h expected %h", i, pc, expPc); end
      end
      nChecks++; if (state !== 2'b01) begin nFails++; $display("[TB] FAIL run_state: got %b expected 01", state); end
   endtask

   // Continues from test_run, where the counter sits on its terminal count.
   task automatic test_branch();
      branch_taken = 1'b1;
      branch_target = 32'h103;
      cyc();
      nChecks++; if (pc !== 32'h100) begin nFails++; $display("[TB] FAIL branch_pc: got %h expected %h", pc, 32'h100); end
      nChecks++; if (commit !== 1'b1) begin nFails++; $display("[TB] FAIL branch_commit: got %b expected 1", commit); end
      branch_taken = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         cyc();
         nChecks++; if (commit !== (j == 4)) begin nFails++; $display("[TB] FAIL branch_next_commit[%0d]: got %b expected %b", j, commit, (j == 4)); end
      end
      nChecks++; if (pc !== 32'h104) begin nFails++; $display("[TB] FAIL branch_next_pc: got %h expected %h", pc, 32'h104); end
      run_sw = 1'b0;
      cyc();
   endtask

   task automatic test_run_exit();
      applyStimulus();
      run_sw = 1'b1;
      cyc(4);
      run_sw = 1'b0;
      cyc();
      nChecks++; if (state !== 2'b00) begin nFails++; $display("[TB] FAIL exit_state: got %b expected 00", state); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL exit_commit: got %b expected 0", commit); end
      nChecks++; if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL exit_pc: got %h expected %h", pc, 32'h0); end
   endtask

   task automatic test_step();
      applyStimulus();
      step_btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         nChecks++; if (commit !== (i == STEP_LAT + 1)) begin nFails++; $display("[TB] FAIL step_commit[%0d]: got %b expected %b", i, commit, (i == STEP_LAT + 1)); end
      end
      settleButton();
      nChecks++; if (pc !== 32'h4) begin nFails++; $display("[TB] FAIL step_pc: got %h expected %h", pc, 32'h4); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL step_idle_commit: got %b expected 0", commit); end
   endtask

   task automatic test_halt();
      applyStimulus();
      run_sw = 1'b1;
      cyc(9);
      nChecks++; if (pc !== 32'h8) begin nFails++; $display("[TB] FAIL halt_pre_pc: got %h expected %h", pc, 32'h8); end
      cyc(3);
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      nChecks++; if (state !== 2'b10) begin nFails++; $display("[TB] FAIL halt_state: got %b expected 10", state); end
      nChecks++; if (pc !== 32'h8) begin nFails++; $display("[TB] FAIL halt_pc: got %h expected %h", pc, 32'h8); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL halt_commit: got %b expected 0", commit); end
      applyStep();
      nChecks++; if (state !== 2'b10) begin nFails++; $display("[TB] FAIL halt_step_run_state: got %b expected 10", state); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL halt_step_run_commit: got %b expected 0", commit); end
      settleButton();
      run_sw = 1'b0;
      applyStep();
      nChecks++; if (state !== 2'b00) begin nFails++; $display("[TB] FAIL halt_ack_state: got %b expected 00", state); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL halt_ack_commit: got %b expected 0", commit); end
      settleButton();
      nChecks++; if (pc !== 32'h8) begin nFails++; $display("[TB] FAIL halt_ack_pc: got %h expected %h", pc, 32'h8); end
   endtask

   task automatic test_wrap_and_reset();
      applyStimulus();
      branch_taken = 1'b1;
      branch_target = 32'hFFFF_FFFF;
      applyStep();
      nChecks++; if (pc !== 32'hFFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_setup_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
      nChecks++; if (commit !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_setup_commit: got %b expected 1", commit); end
      settleButton();
      branch_taken = 1'b0;
      #1;
      nChecks++; if (pc_next !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_pc_next: got %h expected %h", pc_next, 32'h0); end
      applyStep();
      nChecks++; if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
      nChecks++; if (commit !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_commit: got %b expected 1", commit); end
      settleButton();
      // Reset lands on the edge that would otherwise carry the first RUN commit.
      run_sw = 1'b1;
      cyc(4);
      rst = 1'b1;
      cyc();
      nChecks++; if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL midrun_reset_pc: got %h expected %h", pc, 32'h0); end
      nChecks++; if (state !== 2'b00) begin nFails++; $display("[TB] FAIL midrun_reset_state: got %b expected 00", state); end
      nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL midrun_reset_commit: got %b expected 0", commit); end
      run_sw = 1'b0;
      rst = 1'b0;
      cyc();
   endtask

`ifdef SEQ_DEBOUNCE_EN
   task automatic test_debounce();
      applyStimulus();
      step_btn = 1'b1;
      cyc(2);
      step_btn = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         nChecks++; if (commit !== 1'b0) begin nFails++; $display("[TB] FAIL glitch_commit[%0d]: got %b expected 0", i, commit); end
      end
      nChecks++; if (pc !== 32'h0) begin nFails++; $display("[TB] FAIL glitch_pc: got %h expected %h", pc, 32'h0); end
      step_btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (i == 6) step_btn = 1'b0;
         nChecks++; if (commit !== (i == 6)) begin nFails++; $display("[TB] FAIL debounce_commit[%0d]: got %b expected %b", i, commit, (i == 6)); end
      end
      nChecks++; if (pc !== 32'h4) begin nFails++; $display("[TB] FAIL debounce_pc: got %h expected %h", pc, 32'h4); end
   endtask
`endif

   initial begin
      test_reset();
      test_run();
      test_branch();
      test_run_exit();
      test_step();
      test_halt();
      test_wrap_and_reset();
`ifdef SEQ_DEBOUNCE_EN
      test_debounce();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
